// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants, width helpers and the writeback
// request bundle for the scoreboarded register file.
package regfile_pkg;

  localparam int SP_IDX_DEF  = 2;
  localparam int SP_INIT_DEF = 2048;

  function automatic int addr_w(input int nregs);
    return $clog2(nregs);
  endfunction

  function automatic int cnt_w(input int nregs);
    return $clog2(nregs + 1);
  endfunction

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = addr_w(NREGS_DEF);

  typedef struct packed {
    logic              valid;
    logic [AW_DEF-1:0] addr;
    logic [XLEN_DEF-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regfile_bypass.sv
// regfile_bypass: picks the highest-index writeback port matching
// a nonzero read address; the hit flag also masks the busy bit.
module regfile_bypass
  import regfile_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int NWR  = 2
) (
  input  logic [AW-1:0]       rd_addr,
  input  logic [NWR-1:0]      wb_valid,
  input  logic [NWR*AW-1:0]   wb_addr,
  input  logic [NWR*XLEN-1:0] wb_data,
  output logic                hit,
  output logic [XLEN-1:0]     data
);

  // later ports override earlier ones, so the highest index wins
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int j = 0; j < NWR; j++) begin
      if (wb_valid[j] && rd_addr != '0 &&
          wb_addr[j*AW +: AW] == rd_addr) begin
        hit  = 1'b1;
        data = wb_data[j*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with writeback bypass and
// per-register busy scoreboard. Optional dbg_regs via REGFILE_DBG_EN.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NREGS   = 32,
  parameter int NRD     = 2,
  parameter int NWR     = 2,
  parameter int SP_IDX  = SP_IDX_DEF,
  parameter int SP_INIT = SP_INIT_DEF,
  localparam int AW     = addr_w(NREGS),
  localparam int PW     = cnt_w(NREGS)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]  rd_data,
  output logic [NRD-1:0]       rd_busy,
  input  logic                 iss_valid,
  input  logic [AW-1:0]        iss_addr,
  output logic                 iss_ready,
  input  logic [NWR-1:0]       wb_valid,
  input  logic [NWR*AW-1:0]    wb_addr,
  input  logic [NWR*XLEN-1:0]  wb_data,
  output logic [PW-1:0]        pend_cnt
`ifdef REGFILE_DBG_EN
  ,
  output logic [NREGS*XLEN-1:0] dbg_regs
`endif
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nx;
  logic [NREGS-1:0] wb_hit;
  logic [NREGS-1:0] claim;
  logic [PW-1:0]    cnt_nx;
  logic [NRD-1:0]   byp_hit;
  logic [XLEN-1:0]  byp_data [NRD];

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    regfile_bypass #(
      .XLEN (XLEN),
      .AW   (AW),
      .NWR  (NWR)
    ) u_byp (
      .rd_addr  (rd_addr[i*AW +: AW]),
      .wb_valid (wb_valid),
      .wb_addr  (wb_addr),
      .wb_data  (wb_data),
      .hit      (byp_hit[i]),
      .data     (byp_data[i])
    );
  end

  // read ports: bypass first, then array; x0 is hardwired zero
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      if (byp_hit[i])
        rd_data[i*XLEN +: XLEN] = byp_data[i];
      else if (rd_addr[i*AW +: AW] != '0)
        rd_data[i*XLEN +: XLEN] = regs[rd_addr[i*AW +: AW]];
      rd_busy[i] = busy[rd_addr[i*AW +: AW]] && !byp_hit[i];
    end
  end

  // one-hot map of registers released by a writeback this cycle
  always_comb begin
    wb_hit = '0;
    for (int j = 0; j < NWR; j++) begin
      if (wb_valid[j] && wb_addr[j*AW +: AW] != '0)
        wb_hit[wb_addr[j*AW +: AW]] = 1'b1;
    end
  end

  assign iss_ready = !busy[iss_addr] || wb_hit[iss_addr];

  // next busy state: release on wb, a same-cycle claim wins
  always_comb begin
    claim = '0;
    if (iss_valid && iss_ready && iss_addr != '0)
      claim[iss_addr] = 1'b1;
    busy_nx = (busy & ~wb_hit) | claim;
    cnt_nx  = '0;
    for (int i = 0; i < NREGS; i++)
      cnt_nx = cnt_nx + PW'(busy_nx[i]);
  end

  // register array: reset to zero with SP preset, last port wins
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= (i == SP_IDX) ? XLEN'(SP_INIT) : '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wb_valid[j] && wb_addr[j*AW +: AW] != '0)
          regs[wb_addr[j*AW +: AW]] <= wb_data[j*XLEN +: XLEN];
      end
    end
  end

  // scoreboard state and registered pending count
  always_ff @(posedge clk) begin
    if (!rstn) begin
      busy     <= '0;
      pend_cnt <= '0;
    end else begin
      busy     <= busy_nx;
      pend_cnt <= cnt_nx;
    end
  end

`ifdef REGFILE_DBG_EN
  // debug snapshot of the array as it stood before this edge
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREGS; i++)
      dbg_regs[i*XLEN +: XLEN] <= regs[i];
  end
`endif

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed scenarios plus random traffic checked
// against an array-based reference model of the register file.
module tb_regfile_sb;
  import regfile_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        iss_valid;
  logic [4:0]  iss_addr;
  logic        iss_ready;
  logic [1:0]  wb_valid;
  logic [9:0]  wb_addr;
  logic [63:0] wb_data;
  logic [5:0]  pend_cnt;
`ifdef REGFILE_DBG_EN
  logic [1023:0] dbg_regs;
`endif

  always #5 clk = ~clk;

  regfile_sb dut (
    .clk       (clk),
    .rstn      (rstn),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .iss_ready (iss_ready),
    .wb_valid  (wb_valid),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .pend_cnt  (pend_cnt)
`ifdef REGFILE_DBG_EN
    ,
    .dbg_regs  (dbg_regs)
`endif
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] m_regs [32];
  bit          m_busy [32];
  int          m_pend;
  bit          m_init = 0;

  wb_req_t     wb [2];
  logic        cur_r;
  logic        cur_iv;
  logic [4:0]  cur_ia;
  logic [4:0]  cur_a [2];

  wb_req_t     NOWB;
  assign NOWB = '0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit whit(input logic [4:0] a);
    for (int j = 0; j < 2; j++)
      if (wb[j].valid && wb[j].addr == a && a != 0) return 1;
    return 0;
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (a == 0) return 0;
    for (int j = 1; j >= 0; j--)
      if (wb[j].valid && wb[j].addr == a) return wb[j].data;
    return m_regs[a];
  endfunction

  function automatic bit exp_ready(input logic [4:0] a);
    return (a == 0) || !m_busy[a] || whit(a);
  endfunction

  task automatic drive(input logic r, input logic [4:0] a0,
                       input logic [4:0] a1, input logic iv,
                       input logic [4:0] ia, input wb_req_t w0,
                       input wb_req_t w1);
    @(negedge clk);
    cur_r = r; cur_iv = iv; cur_ia = ia;
    cur_a[0] = a0; cur_a[1] = a1;
    wb[0] = w0; wb[1] = w1;
    rstn      = r;
    rd_addr   = {a1, a0};
    iss_valid = iv;
    iss_addr  = ia;
    wb_valid  = {w1.valid, w0.valid};
    wb_addr   = {w1.addr, w0.addr};
    wb_data   = {w1.data, w0.data};
    #1;
    if (m_init) begin
      chk("rd0", rd_data[31:0], exp_read(a0));
      chk("rd1", rd_data[63:32], exp_read(a1));
      chk("busy0", rd_busy[0], m_busy[a0] && !whit(a0));
      chk("busy1", rd_busy[1], m_busy[a1] && !whit(a1));
      chk("ready", iss_ready, exp_ready(ia));
      chk("pend", pend_cnt, m_pend);
    end
  endtask

  task automatic tick();
    bit acc;
    @(posedge clk);
    acc = cur_iv && exp_ready(cur_ia);
    if (!cur_r) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = (i == 2) ? 32'd2048 : 32'd0;
        m_busy[i] = 0;
      end
      m_init = 1;
    end else begin
      for (int j = 0; j < 2; j++)
        if (wb[j].valid && wb[j].addr != 0) begin
          m_regs[wb[j].addr] = wb[j].data;
          m_busy[wb[j].addr] = 0;
        end
      if (acc && cur_ia != 0) m_busy[cur_ia] = 1;
    end
    m_pend = 0;
    for (int i = 0; i < 32; i++) m_pend += int'(m_busy[i]);
  endtask

  function automatic wb_req_t mk(input logic [4:0] a,
                                 input logic [31:0] d);
    wb_req_t w;
    w.valid = 1'b1; w.addr = a; w.data = d;
    return w;
  endfunction

  initial begin
    rstn = 1'b0; rd_addr = '0; iss_valid = 1'b0; iss_addr = '0;
    wb_valid = '0; wb_addr = '0; wb_data = '0;

    // reset
    drive(0, 0, 0, 0, 0, mk(6, 32'h99), NOWB);
    tick();
    drive(1, 2, 13, 0, 7, NOWB, NOWB);
    chk("rst_sp", rd_data[31:0], 64'd2048);
    chk("rst_r13", rd_data[63:32], 64'd0);
    chk("rst_pend", pend_cnt, 64'd0);
    chk("rst_rdy", iss_ready, 64'd1);
    tick();
    drive(1, 6, 0, 0, 0, NOWB, NOWB);
    chk("rst_drop_wb", rd_data[31:0], 64'd0);
    tick();

    // bypass priority
    drive(1, 5, 5, 0, 0, mk(5, 32'hAAAA), mk(5, 32'hBBBB));
    chk("byp_pri", rd_data[31:0], 64'hBBBB);
    tick();
    drive(1, 5, 0, 0, 0, NOWB, NOWB);
    chk("byp_arr", rd_data[31:0], 64'hBBBB);
    tick();

    // scoreboard claim / release / reclaim
    drive(1, 7, 0, 1, 7, NOWB, NOWB);
    tick();
    drive(1, 7, 0, 1, 7, NOWB, NOWB);
    chk("sb_busy", rd_busy[0], 64'd1);
    chk("sb_pend1", pend_cnt, 64'd1);
    chk("sb_waw", iss_ready, 64'd0);
    tick();
    drive(1, 7, 0, 1, 7, mk(7, 32'h1111), NOWB);
    chk("sb_wb_busy", rd_busy[0], 64'd0);
    chk("sb_wb_rdy", iss_ready, 64'd1);
    chk("sb_wb_data", rd_data[31:0], 64'h1111);
    tick();
    drive(1, 7, 0, 0, 0, NOWB, NOWB);
    chk("sb_reclaim", rd_busy[0], 64'd1);
    chk("sb_pend2", pend_cnt, 64'd1);
    tick();
    drive(1, 7, 0, 0, 0, NOWB, mk(7, 32'h2222));
    tick();

    // x0
    drive(1, 0, 0, 1, 0, mk(0, 32'h1234), NOWB);
    chk("x0_rdy", iss_ready, 64'd1);
    tick();
    drive(1, 0, 0, 0, 0, NOWB, NOWB);
    chk("x0_rd", rd_data[31:0], 64'd0);
    chk("x0_pend", pend_cnt, 64'd0);
    tick();

    // reset mid-flight
    drive(1, 0, 0, 1, 3, NOWB, NOWB);
    tick();
    drive(1, 0, 0, 1, 4, NOWB, NOWB);
    tick();
    drive(0, 0, 0, 0, 0, NOWB, NOWB);
    tick();
    drive(1, 3, 4, 0, 0, mk(3, 32'h55), NOWB);
    tick();
    drive(1, 3, 4, 0, 0, NOWB, NOWB);
    chk("mid_data", rd_data[31:0], 64'h55);
    chk("mid_busy", rd_busy, 64'd0);
    chk("mid_pend", pend_cnt, 64'd0);
    tick();

`ifdef REGFILE_DBG_EN
    drive(1, 0, 0, 0, 0, mk(9, 32'h77), NOWB);
    tick();
    drive(1, 0, 0, 0, 0, NOWB, NOWB);
    tick();
    drive(1, 0, 0, 0, 0, NOWB, NOWB);
    chk("dbg9", dbg_regs[9*32 +: 32], 64'h77);
    chk("dbg_sp", dbg_regs[2*32 +: 32], 64'd2048);
    tick();
`endif

    // random traffic, narrow address range to force conflicts
    for (int n = 0; n < 600; n++) begin
      wb_req_t w [2];
      logic [4:0] a [4];
      int lim;
      lim = ($urandom_range(0, 3) == 0) ? 31 : 7;
      for (int k = 0; k < 4; k++) a[k] = 5'($urandom_range(0, lim));
      for (int j = 0; j < 2; j++) begin
        w[j].valid = 1'($urandom_range(0, 1));
        w[j].addr  = 5'($urandom_range(0, lim));
        w[j].data  = $urandom;
      end
      drive(($urandom_range(0, 63) != 0), a[0], a[1],
            1'($urandom_range(0, 1)), a[2], w[0], w[1]);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-port integer register file with built-in scoreboard for the pipelined RISC-V core. It has NRD combinational read ports, NWR writeback ports with same-cycle bypass, and per-register busy bits. The issue stage claims a destination register; a writeback releases it. It replaces the single-issue 2R/1W register file and gives the decode stage RAW/WAW hazard information directly.

## Interface
- XLEN, 32: data width.
- NREGS, 32: number of architectural registers (power of two, ≥ 4); AW = $clog2(NREGS).
- NRD, 2: read ports.
- NWR, 2: writeback ports.
- SP_IDX, 2: index of the stack pointer.
- SP_INIT, 2048: reset value of register SP_IDX.

- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- rd_addr  in  NRD×AW  read addresses.
- rd_data  out  NRD×XLEN  read data, bypassed.
- rd_busy  out  NRD  register has an outstanding claim not satisfied this cycle.
- iss_valid  in  1  issue stage requests a claim on iss_addr.
- iss_addr  in  AW  destination being claimed.
- iss_ready  out  1  claim accepted when iss_valid && iss_ready.
- wb_valid  in  NWR  writeback strobes.
- wb_addr  in  NWR×AW  writeback destinations.
- wb_data  in  NWR×XLEN  writeback data.
- pend_cnt  out  $clog2(NREGS+1)  registered count of busy registers.
- dbg_regs  out  NREGS×XLEN  registered snapshot (only with REGFILE_DBG_EN).

## Operation
- Register 0 reads 0, ignores writes, and is never busy. A claim on address 0 is always ready and has no effect.
- Write at posedge: for each valid wb port with a nonzero address, regs[wb_addr] <= wb_data. If several ports hit the same address, the highest-index port wins.
- Read: rd_data = wb_data of the highest-index valid wb port matching a nonzero rd_addr; otherwise regs[rd_addr].
- Busy bit set: at posedge on an accepted claim with a nonzero address.
- Busy bit clear: at posedge when any valid wb hits the address, unless that address is being claimed in the same cycle. In that case the bit stays 1 (the new claim wins).
- rd_busy[i] = busy[rd_addr[i]] && no valid wb hit on rd_addr[i] this cycle.
- iss_ready = !busy[iss_addr] || valid wb hit on iss_addr this cycle. This blocks a WAW while the older writer is still in flight.
- A wb to a non-busy register is legal: data is written and busy stays 0.
- pend_cnt is the population count of next-state busy, registered.

## Timing
- Reads, rd_busy and iss_ready are combinational, with zero latency.
- Writes become visible from the array the cycle after the wb; in the wb cycle they are visible through the bypass.
- Busy and pend_cnt update one cycle after the claim or wb.
- Reset (rstn=0 at posedge):
  - all regs become 0 except regs[SP_IDX]=SP_INIT;
  - all busy bits become 0 and pend_cnt becomes 0;
  - dbg_regs holds the reset values one cycle later;
  - wb and claims in that cycle are discarded.
- Reset mid-operation drops every outstanding claim. Late wbs after reset then behave as wbs to non-busy registers.

## Configuration
- REGFILE_DBG_EN defined: dbg_regs port exists and is updated every posedge with the array contents pre-write, i.e. one cycle behind.
- REGFILE_DBG_EN undefined: the port and its registers are absent.
- Functional behaviour is otherwise identical.

## Structure
- regfile_pkg holds:
  - reset constants SP_IDX_DEF and SP_INIT_DEF;
  - the function computing AW and pend_cnt width;
  - the typedef for a writeback request struct {valid, addr, data}.
- One sub-module, regfile_bypass, instantiated NRD times. It selects the highest-index matching wb port and produces data plus a hit flag, which is reused for rd_busy.

## Test plan
- Reset: rstn=0 for one cycle → every read returns 0 except addr 2 = 2048; pend_cnt=0; iss_ready=1.
- Bypass/priority: wb0 {5,0xAAAA} and wb1 {5,0xBBBB} in the same cycle, rd_addr0=5 → rd_data=0xBBBB that cycle and the next.
- Scoreboard: claim 7 → next cycle rd_busy=1, pend_cnt=1, and claim 7 is refused (iss_ready=0). In the wb-7 cycle rd_busy=0 and iss_ready=1; a claim then accepted keeps busy=1 and pend_cnt=1.
- x0: claim 0 plus wb {0,0x1234} → read 0 returns 0, pend_cnt=0.
- Reset mid-flight: claims on 3 and 4, rstn=0, then wb {3,0x55} → busy clear, pend_cnt=0, regs[3]=0x55.
- With REGFILE_DBG_EN: wb {9,0x77} → dbg_regs[9]=0x77 two posedges after the wb.
